da_fir_sequencer: RTL and testbench

Control and sequencing block for the 8-tap distributed-arithmetic (DA) FIR datapath. It accepts one signed sample per handshake and keeps the tap delay line. Each of the DATA_W bit-planes of the taps becomes an address for the external coefficient LUT, and the block shift-accumulates the returned partial sums, subtracting the sign-bit plane. It then presents the filtered result on a valid/ready output. It sits between the sample source and the downstream consumer, and owns the bit-serial schedule that the datapath depends on.

---
 rtl/da_fir_sequencer_pkg.sv | 31 +++
 rtl/da_fir_sequencer_if.sv | 40 ++++
 rtl/da_fir_sequencer_tap_line.sv | 57 +++++
 rtl/da_fir_sequencer.sv | 116 +++++++++++
 tb/tb_da_fir_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/da_fir_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// da_pkg
//   Shared constants and types for the distributed-arithmetic FIR sequencer.
//   DATA_W : sample width, also the number of bit-plane cycles per sample
//   TAPS   : number of taps, equal to the coefficient LUT address width
//   LUT_W  : signed width of one LUT partial sum
//   ACC_W  : signed accumulator / result width
//   BIT_W  : width of the bit-plane counter
// ----------------------------------------------------------------------------
package da_pkg;

   localparam int DATA_W = 8;
   localparam int TAPS   = 8;
   localparam int LUT_W  = 16;
   localparam int ACC_W  = 32;
   localparam int BIT_W  = $clog2(DATA_W);

   // Sequencer phases: waiting for a sample, walking the bit-planes,
   // holding the result for the consumer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BITS = 2'd1,
      DONE = 2'd2
   } state_e;

   // Sign-extend one LUT partial sum to accumulator width.
   function automatic logic [ACC_W-1:0] sext_lut(input logic [LUT_W-1:0] v);
      return {{(ACC_W-LUT_W){v[LUT_W-1]}}, v};
   endfunction

endpackage

// File: rtl/da_fir_sequencer_if.sv
// ----------------------------------------------------------------------------
// da_fir_sequencer_if
//   Bundles the three buses around the sequencer:
//     sample input  : in_valid / in_ready / in_data
//     LUT port      : lut_en / lut_addr out, lut_data back in the same cycle
//     result output : out_valid / out_ready / out_sum
//   Modports:
//     master : the surroundings (sample source, LUT, consumer)
//     slave  : the sequencer itself
//
//   Handshake rule for both streams: a transfer happens on a rising clk edge
//   where valid and ready are both high. The producer keeps valid and data
//   stable until that edge; ready may change freely. The sequencer's in_ready
//   is only high in IDLE, and out_valid stays high with out_sum frozen until
//   the consumer takes it.
// ----------------------------------------------------------------------------
interface da_fir_sequencer_if;
   import da_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [TAPS-1:0]   lut_addr;
   logic              lut_en;
   logic [LUT_W-1:0]  lut_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;

   modport master (
      output in_valid, in_data, lut_data, out_ready,
      input  in_ready, lut_addr, lut_en, out_valid, out_sum
   );

   modport slave (
      input  in_valid, in_data, lut_data, out_ready,
      output in_ready, lut_addr, lut_en, out_valid, out_sum
   );

endinterface

// File: rtl/da_fir_sequencer_tap_line.sv
// ----------------------------------------------------------------------------
// da_tap_line
//   TAPS x DATA_W sample delay line. tap 0 holds the newest sample.
//   Ports:
//     clk, reset  : clock, synchronous active-high clear of every tap
//     shift_en_i  : push data_i into tap 0, every tap moves one place older
//     data_i      : incoming sample
//     bit_idx_i   : which bit-plane to expose
//     addr_o      : bit-plane address, addr_o[k] = tap[k][bit_idx_i]
// ----------------------------------------------------------------------------
module da_tap_line
   import da_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [BIT_W-1:0]  bit_idx_i,
   output logic [TAPS-1:0]   addr_o
);

   logic [DATA_W-1:0] taps_q [TAPS];
   logic [DATA_W-1:0] taps_d [TAPS];

   always_comb begin
      for (int k = 0; k < TAPS; k++) begin
         taps_d[k] = taps_q[k];
      end
      if (shift_en_i) begin
         taps_d[0] = data_i;
         for (int k = 1; k < TAPS; k++) begin
            taps_d[k] = taps_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) begin
            taps_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < TAPS; k++) begin
            taps_q[k] <= taps_d[k];
         end
      end
   end

   // Transpose: one bit of every tap forms the LUT address.
   always_comb begin
      addr_o = '0;
      for (int k = 0; k < TAPS; k++) begin
         addr_o[k] = taps_q[k][bit_idx_i];
      end
   end

endmodule

// File: rtl/da_fir_sequencer.sv
// ----------------------------------------------------------------------------
// da_fir_sequencer
//   Bit-serial distributed-arithmetic FIR control. Accepts one signed sample
//   per handshake, walks the DATA_W bit-planes of the tap line (LSB first),
//   uses each plane as the address of an external coefficient LUT and
//   shift-accumulates the returned partial sums. The sign-bit plane is
//   subtracted, which makes the result correct for two's complement taps.
//   Ports:
//     clk, reset : clock, synchronous active-high reset (clears all state)
//     bus        : sample input, LUT port and result output (slave modport)
//     busy       : high whenever the sequencer is not in IDLE
//     dbg_state  : current FSM state
//   Timing: accept edge is cycle 0, bit-planes run in cycles 1..DATA_W,
//   out_valid rises in cycle DATA_W+1.
// ----------------------------------------------------------------------------
module da_fir_sequencer
   import da_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   da_fir_sequencer_if.slave   bus,
   output logic                busy,
   output state_e              dbg_state
);

   state_e            state_q, state_d;
   logic [BIT_W-1:0]  bit_q,   bit_d;
   logic [ACC_W-1:0]  acc_q,   acc_d;
   logic [ACC_W-1:0]  sum_q,   sum_d;

   logic              accept;
   logic [TAPS-1:0]   plane;
   logic [ACC_W-1:0]  lut_term;
   logic              last_bit;

   // Reset wins over a simultaneous in_valid, so acceptance is gated here too.
   assign accept   = (state_q == IDLE) && bus.in_valid && !reset;
   assign lut_term = sext_lut(bus.lut_data) << bit_q;
   assign last_bit = (bit_q == BIT_W'(DATA_W-1));

   da_tap_line u_tap_line (
      .clk        (clk),
      .reset      (reset),
      .shift_en_i (accept),
      .data_i     (bus.in_data),
      .bit_idx_i  (bit_q),
      .addr_o     (plane)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         bit_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_d        = bit_q;
      acc_d        = acc_q;
      sum_d        = sum_q;
      bus.in_ready = 1'b0;
      bus.lut_en   = 1'b0;
      bus.lut_addr = '0;
      bus.out_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            bus.in_ready = !reset;
            if (accept) begin
               acc_d   = '0;
               bit_d   = '0;
               state_d = BITS;
            end
         end

         BITS: begin
            bus.lut_en   = 1'b1;
            bus.lut_addr = plane;
            if (last_bit) begin
               // Sign plane carries weight -2^(DATA_W-1).
               acc_d   = acc_q - lut_term;
               sum_d   = acc_d;
               bit_d   = '0;
               state_d = DONE;
            end else begin
               acc_d = acc_q + lut_term;
               bit_d = bit_q + 1'b1;
            end
         end

         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.out_sum = sum_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_da_fir_sequencer.sv
module tb_da_fir_sequencer;
   import da_pkg::*;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   reset = 1'b1;
   logic   busy;
   state_e dbg_state;

   always #5 clk = ~clk;

   da_fir_sequencer_if bus ();

   da_fir_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- LUT model: LUT[a] = sum h[k]*a[k] ----------------
   int h [TAPS] = '{1, 2, 3, 4, 5, 6, 7, 8};
   int lut_v;

   always_comb begin
      lut_v = 0;
      for (int k = 0; k < TAPS; k++) begin
         if (bus.lut_addr[k]) lut_v = lut_v + h[k];
      end
      bus.lut_data = lut_v[LUT_W-1:0];
   end

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;
   int n_out = 0;
   bit started = 1'b0;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase 0 = idle, 1..DATA_W = bit-plane cycle (b = phase-1),
   // DATA_W+1 = result held for the consumer.
   int          m_phase = 0;
   int          m_taps [TAPS];
   int          m_pending = 0;
   int          m_last = 0;
   logic [31:0] exp_q [$];
   int          e_addr;

   initial begin
      for (int k = 0; k < TAPS; k++) m_taps[k] = 0;
   end

   always @(negedge clk) begin
      if (started) begin
         check("in_ready", bus.in_ready, (m_phase == 0 && !reset));
         check("busy", busy, (m_phase != 0));
         check("idle_state", (dbg_state == IDLE), (m_phase == 0));
         check("lut_en", bus.lut_en, (m_phase >= 1 && m_phase <= DATA_W));
         e_addr = 0;
         if (m_phase >= 1 && m_phase <= DATA_W) begin
            for (int k = 0; k < TAPS; k++)
               e_addr = e_addr | (((m_taps[k] >>> (m_phase - 1)) & 1) << k);
         end
         check("lut_addr", int'(bus.lut_addr), e_addr);
         check("out_valid", bus.out_valid, (m_phase == DATA_W + 1));
         check("out_sum", int'($signed(bus.out_sum)), m_last);
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_result", 1, 0);
            else check("scoreboard", int'($signed(bus.out_sum)), int'($signed(exp_q.pop_front())));
         end
      end
      // advance model to the state after the coming rising edge
      if (reset) begin
         m_phase = 0;
         m_last  = 0;
         for (int k = 0; k < TAPS; k++) m_taps[k] = 0;
         exp_q.delete();
      end else if (m_phase == 0) begin
         if (bus.in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
            m_taps[0] = int'($signed(bus.in_data));
            m_pending = 0;
            for (int k = 0; k < TAPS; k++) m_pending = m_pending + h[k] * m_taps[k];
            m_phase = 1;
         end
      end else if (m_phase < DATA_W) begin
         m_phase = m_phase + 1;
      end else if (m_phase == DATA_W) begin
         m_last = m_pending;
         exp_q.push_back(m_pending);
         m_phase = DATA_W + 1;
      end else if (bus.out_ready) begin
         m_phase = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Present a sample, wait for acceptance, then for out_valid. Returns at
   // the edge after out_valid was seen (+1), with the result captured.
   task automatic send_sample(input int s, output int res);
      bit got;
      int lat;
      res = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = s[DATA_W-1:0];
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (bus.in_ready) got = 1'b1;
      end
      if (!got) begin
         check("accept_timeout", 0, 1);
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         got = 1'b0;
         lat = 0;
         for (int i = 1; i <= 64 && !got; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
               got = 1'b1;
               lat = i;
            end
         end
         if (!got) check("result_timeout", 0, 1);
         else begin
            check("latency", lat, DATA_W + 1);
            res = int'($signed(bus.out_sum));
         end
      end
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   int r;
   int hold;
   int n_en;
   int snap;
   int imp_exp [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
   int sched   [8]  = '{0, 1, 0, 1, 1, 0, 1, 0};
   int seen    [8];

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      started = 1'b1;
      // sample offered while reset is still high must be dropped
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h7F;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("post_reset_busy", busy, 0);
      check("post_reset_ready", bus.in_ready, 1);
      @(posedge clk); #1;

      // impulse
      for (int i = 0; i < 10; i++) begin
         send_sample((i == 0) ? 1 : 0, r);
         check("impulse", r, imp_exp[i]);
      end

      // sign plane
      pulse_reset();
      send_sample(-128, r);
      check("sign_plane_a", r, -128);
      send_sample(0, r);
      check("sign_plane_b", r, -256);

      // full scale
      pulse_reset();
      for (int i = 0; i < 8; i++) send_sample(127, r);
      check("full_scale_pos", r, 4572);
      for (int i = 0; i < 8; i++) send_sample(-128, r);
      check("full_scale_neg", r, -4608);

      // backpressure
      bus.out_ready = 1'b0;
      send_sample(int'($urandom_range(0, 255)) - 128, r);
      hold = r;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data  = 8'($urandom_range(0, 255));
         @(negedge clk);
         check("bp_valid", bus.out_valid, 1);
         check("bp_sum", int'($signed(bus.out_sum)), hold);
         check("bp_ready", bus.in_ready, 0);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_release_ready", bus.in_ready, 1);
      check("bp_release_valid", bus.out_valid, 0);
      @(posedge clk); #1;

      // reset in the middle of the bit-planes
      snap = n_out;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom_range(1, 255));
      @(negedge clk);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midreset_ready", bus.in_ready, 1);
      check("midreset_valid", bus.out_valid, 0);
      check("midreset_idle", (dbg_state == IDLE), 1);
      repeat (12) begin @(posedge clk); #1; end
      check("midreset_no_result", n_out, snap);
      send_sample(1, r);
      check("midreset_impulse", r, 1);

      // LUT schedule for 0x5A into empty taps
      pulse_reset();
      n_en = 0;
      for (int i = 0; i < 8; i++) seen[i] = -1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      @(negedge clk);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.lut_en) begin
            n_en++;
            if (c <= 8) seen[c-1] = int'(bus.lut_addr[0]);
         end
         if (bus.out_valid) check("sched_result", int'($signed(bus.out_sum)), 90);
      end
      check("sched_en_count", n_en, 8);
      for (int i = 0; i < 8; i++) check("sched_bit", seen[i], sched[i]);
      @(posedge clk); #1;

      // randomized traffic with random gaps and backpressure
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         bus.out_ready = 1'($urandom_range(0, 1));
         send_sample(int'($urandom_range(0, 255)) - 128, r);
         if (!bus.out_ready) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("leftover_results", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
